reg_readback_ser: RTL and testbench
===================================

Name: reg_readback_ser

Overview:
- Reader-side counterpart to the datapath register. Accepts a parallel word through a valid/ready load handshake and shifts it out one bit per accepted beat on a serial valid/ready stream.
- Used to read back register contents over a narrow debug/readback path in the datapath test harness.
- Tracks a wrap-around count of completed words for host-side sanity checks.

Parameters:
- DATAWIDTH, 32, width of the parallel word; legal range 2..64.
- MSB_FIRST, 1, 1 = bit DATAWIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- d  input  DATAWIDTH  parallel word to read back.
- load_valid  input  1  d is valid.
- load_ready  output  1  block can capture d.
- sdo  output  1  serial data bit.
- sdo_valid  output  1  sdo is valid.
- sdo_last  output  1  current bit is the final bit of the word.
- sdo_ready  input  1  downstream accepts the current bit.
- busy  output  1  word in flight (state SHIFT).
- words_sent  output  16  count of fully sent words; wraps 0xFFFF->0x0000.

Behaviour:
- One clock. Reset is asynchronous and active-high: Rst high forces all state immediately, independent of Clk.
- Reset values:
  - state=IDLE, shift register=0, bit counter=0, words_sent=0.
  - sdo=0, sdo_valid=0, sdo_last=0, busy=0, load_ready=1.
- States: IDLE and SHIFT. load_ready = (state==IDLE). busy = sdo_valid = (state==SHIFT).
- IDLE:
  - If load_valid=1 at the rising edge, capture d into the shift register, clear the bit counter, and go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - sdo = shreg[DATAWIDTH-1] if MSB_FIRST, else shreg[0]. sdo is registered, not a combinational path from d.
  - sdo_last = (bitcnt == DATAWIDTH-1).
  - Load handshake ignored; load_valid has no effect and d is not sampled.
- Transfer rule: a bit transfers when sdo_valid && sdo_ready at a rising edge.
  - On transfer: shift the register by one toward the output end, zero-fill the vacated bit, and increment bitcnt.
  - With sdo_ready=0: sdo, sdo_last and bitcnt hold indefinitely (stall). No bit is lost or duplicated.
- Last-bit transfer: when the last bit transfers, go to IDLE and increment words_sent (modulo 2^16).
  - load_ready rises in the cycle after the last transfer.
  - A load presented that cycle starts the next word.
  - Minimum period is DATAWIDTH+1 cycles per word.
- Latency: load accepted at edge N; first bit valid in the cycle after edge N; with sdo_ready held high, last bit transfers at edge N+DATAWIDTH.
- Counter width is clog2(DATAWIDTH), minimum 1 bit. bitcnt never exceeds DATAWIDTH-1.
- sdo_valid never drops mid-word except on Rst.
- sdo outside SHIFT is don't-care in spec; the bench checks only when sdo_valid=1. The implementation drives 0.
- Reset mid-word: the word is abandoned with no partial count, words_sent clears, and the block is in IDLE with load_ready=1 after Rst deasserts.
- Rst asserted at the same edge as load_valid: reset wins and nothing is captured.
- sdo_ready may be asserted while sdo_valid=0; this has no effect.

Test Plan:
- DATAWIDTH=8, MSB_FIRST=1, d=0xA5, load_valid for 1 cycle, sdo_ready=1 -> sdo sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; sdo_last only on the 8th; words_sent=1; load_ready=1 the next cycle.
- DATAWIDTH=8, MSB_FIRST=0, d=0xA5 -> sdo sequence 1,0,1,0,0,1,0,1 (LSB first); then d=0x01 -> 1,0,0,0,0,0,0,0.
- Backpressure, DATAWIDTH=32, d=0xDEADBEEF, sdo_ready toggling 1,0,0,1,... -> serialized bits reassemble to 0xDEADBEEF with no drop or repeat; sdo stable while stalled; load_valid pulses with d=0x12345678 during SHIFT are ignored.
- Back-to-back: two words 0x3C then 0xC3 with load_valid held high -> second load captured the cycle after the first word's sdo_last transfer; 18 cycles total with sdo_ready=1.
- Async reset during bit 4 of 0xFF -> all outputs go to reset values immediately without waiting for a Clk edge; words_sent=0; next load of 0x81 sends 1,0,0,0,0,0,0,1 correctly.
- Wrap: preload by sending 65536 words of 0x00 -> words_sent reads 0x0000 after the final word and 0xFFFF one word earlier.

Source files
------------

// File: rtl/reg_readback_ser.sv
// reg_readback_ser: parallel-load, serial-out readback shifter.
// Handshakes: a transfer on either interface happens only at a rising Clk
// edge where that interface's valid and ready are both high; valid is never
// withdrawn once raised until the transfer completes (except on Rst).
// A word is captured from d in IDLE and sent one bit per accepted serial
// beat. words_sent counts completed words and wraps at 16 bits.
module reg_readback_ser #(
  parameter int DATAWIDTH = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 sdo,
  output logic                 sdo_valid,
  output logic                 sdo_last,
  input  logic                 sdo_ready,
  output logic                 busy,
  output logic [15:0]          words_sent
);

  // Bit counter is wide enough to hold DATAWIDTH-1, never narrower than 1 bit.
  localparam int CW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATAWIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DATAWIDTH-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [15:0]            words_sent_q, words_sent_d;
  logic                   sdo_q, sdo_d;
  logic                   sdo_valid_q, sdo_valid_d;
  logic                   sdo_last_q, sdo_last_d;
  logic                   load_ready_q, load_ready_d;
  logic [DATAWIDTH-1:0]   shreg_shifted;

  // Shift one place toward the output end, zero-filling the vacated bit.
  always_comb begin
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[DATAWIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[DATAWIDTH-1:1]};
    end
  end

  // Next-state logic; outputs are derived from the next state so that they
  // come straight out of flops and never combinationally from d.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    words_sent_d = words_sent_q;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d  = d;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sdo_ready) begin
          shreg_d = shreg_shifted;
          if (bitcnt_q == LAST_IDX) begin
            bitcnt_d     = '0;
            state_d      = IDLE;
            words_sent_d = words_sent_q + 16'd1;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    sdo_valid_d  = (state_d == SHIFT);
    load_ready_d = (state_d == IDLE);
    sdo_last_d   = (state_d == SHIFT) && (bitcnt_d == LAST_IDX);
    if (state_d == SHIFT) begin
      sdo_d = MSB_FIRST ? shreg_d[DATAWIDTH-1] : shreg_d[0];
    end else begin
      sdo_d = 1'b0;
    end
  end

  // All state and registered outputs; Rst clears everything asynchronously.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      words_sent_q <= 16'd0;
      sdo_q        <= 1'b0;
      sdo_valid_q  <= 1'b0;
      sdo_last_q   <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      words_sent_q <= words_sent_d;
      sdo_q        <= sdo_d;
      sdo_valid_q  <= sdo_valid_d;
      sdo_last_q   <= sdo_last_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign sdo        = sdo_q;
  assign sdo_valid  = sdo_valid_q;
  assign sdo_last   = sdo_last_q;
  assign busy       = sdo_valid_q;
  assign load_ready = load_ready_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_reg_readback_ser.sv
// Bench for reg_readback_ser: three instances (8-bit MSB-first, 8-bit
// LSB-first, 32-bit MSB-first) share clock, reset, d and sdo_ready; each has
// its own load_valid. Expected serial bits come from a bit queue built from
// the word, width and bit order alone.
module tb_reg_readback_ser;

  logic        clk;
  logic        rst;
  logic [31:0] d;
  logic [2:0]  lv;
  logic        rdy;

  logic [2:0]  sdo_v, valid_v, last_v, ld_rdy_v, busy_v;
  logic [15:0] ws_v [3];

  int total = 0;
  int bad   = 0;

  int wid [3] = '{8, 8, 32};
  bit msb [3] = '{1'b1, 1'b0, 1'b1};
  int exp_ws [3];
  logic [0:0] exp_q [$];

  reg_readback_ser #(.DATAWIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .Clk(clk), .Rst(rst), .d(d[7:0]), .load_valid(lv[0]), .load_ready(ld_rdy_v[0]),
    .sdo(sdo_v[0]), .sdo_valid(valid_v[0]), .sdo_last(last_v[0]), .sdo_ready(rdy),
    .busy(busy_v[0]), .words_sent(ws_v[0]));

  reg_readback_ser #(.DATAWIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
    .Clk(clk), .Rst(rst), .d(d[7:0]), .load_valid(lv[1]), .load_ready(ld_rdy_v[1]),
    .sdo(sdo_v[1]), .sdo_valid(valid_v[1]), .sdo_last(last_v[1]), .sdo_ready(rdy),
    .busy(busy_v[1]), .words_sent(ws_v[1]));

  reg_readback_ser #(.DATAWIDTH(32), .MSB_FIRST(1'b1)) u_m32 (
    .Clk(clk), .Rst(rst), .d(d), .load_valid(lv[2]), .load_ready(ld_rdy_v[2]),
    .sdo(sdo_v[2]), .sdo_valid(valid_v[2]), .sdo_last(last_v[2]), .sdo_ready(rdy),
    .busy(busy_v[2]), .words_sent(ws_v[2]));

  // Clock and overall time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference: the bits of w in transmit order for instance s.
  task automatic push_word(input int s, input logic [31:0] w);
    for (int i = 0; i < wid[s]; i++) begin
      if (msb[s]) exp_q.push_back(w[wid[s]-1-i]);
      else        exp_q.push_back(w[i]);
    end
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready pattern 1,0,0,...
  // noise: toggle load_valid with a foreign d while the word is in flight.
  task automatic send_word(input int s, input logic [31:0] w, input int mode, input bit noise);
    int          cyc;
    int          nbits;
    bit          done;
    bit          last_e;
    logic [0:0]  exp_b;
    logic [31:0] got;
    logic [31:0] want;
    @(negedge clk);
    total++;
    if (ld_rdy_v[s] !== 1'b1) begin
      bad++; $display("FAIL load_ready_before_load s=%0d got=%0b exp=1", s, ld_rdy_v[s]);
    end
    d = w; lv[s] = 1'b1;
    @(posedge clk); #1;
    lv[s] = 1'b0;
    exp_q.delete();
    push_word(s, w);
    got = '0; nbits = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 3 == 1);
      endcase
      if (noise) begin
        lv[s] = 1'($urandom_range(0, 1));
        d = 32'h12345678;
      end
      total++;
      if (valid_v[s] !== 1'b1 || busy_v[s] !== 1'b1 || ld_rdy_v[s] !== 1'b0) begin
        bad++; $display("FAIL in_flight_flags s=%0d cyc=%0d got v/b/lr=%b%b%b exp=110",
                        s, cyc, valid_v[s], busy_v[s], ld_rdy_v[s]);
      end
      if (rdy) begin
        exp_b  = exp_q.pop_front();
        last_e = (exp_q.size() == 0);
        total++;
        if (sdo_v[s] !== exp_b) begin
          bad++; $display("FAIL sdo_bit s=%0d bit=%0d got=%b exp=%b", s, nbits, sdo_v[s], exp_b);
        end
        total++;
        if (last_v[s] !== last_e) begin
          bad++; $display("FAIL sdo_last s=%0d bit=%0d got=%b exp=%b", s, nbits, last_v[s], last_e);
        end
        if (msb[s]) got = {got[30:0], sdo_v[s]};
        else        got[nbits] = sdo_v[s];
        nbits++;
        done = last_e;
      end else begin
        total++;
        if (sdo_v[s] !== exp_q[0]) begin
          bad++; $display("FAIL stall_hold s=%0d bit=%0d got=%b exp=%b", s, nbits, sdo_v[s], exp_q[0]);
        end
      end
      @(posedge clk); #1;
    end
    lv[s] = 1'b0;
    if (!done) begin
      bad++; total++;
      $display("FAIL word_timeout s=%0d got=%0d bits exp=%0d", s, nbits, wid[s]);
      exp_q.delete();
    end
    exp_ws[s] = (exp_ws[s] + 1) % 65536;
    want = (wid[s] == 32) ? w : (w & ((32'd1 << wid[s]) - 32'd1));
    total++;
    if (got !== want) begin
      bad++; $display("FAIL reassembly s=%0d got=%0h exp=%0h", s, got, want);
    end
    if (mode == 0) begin
      total++;
      if (cyc != wid[s]) begin
        bad++; $display("FAIL latency s=%0d got=%0d exp=%0d", s, cyc, wid[s]);
      end
    end
    @(negedge clk);
    total++;
    if (ld_rdy_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || valid_v[s] !== 1'b0) begin
      bad++; $display("FAIL after_word_idle s=%0d got lr/b/v=%b%b%b exp=100",
                      s, ld_rdy_v[s], busy_v[s], valid_v[s]);
    end
    total++;
    if (ws_v[s] !== 16'(exp_ws[s])) begin
      bad++; $display("FAIL words_sent s=%0d got=%0d exp=%0d", s, ws_v[s], exp_ws[s]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d = '0; lv = '0; rdy = 1'b0;
    for (int s = 0; s < 3; s++) exp_ws[s] = 0;
    #1;
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({ld_rdy_v[s], valid_v[s], busy_v[s], last_v[s], sdo_v[s]} !== 5'b10000 || ws_v[s] !== 16'd0) begin
        bad++; $display("FAIL reset_values s=%0d got lr/v/b/l/sdo=%b%b%b%b%b ws=%0d exp=10000 ws=0",
                        s, ld_rdy_v[s], valid_v[s], busy_v[s], last_v[s], sdo_v[s], ws_v[s]);
      end
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    // sdo_ready while idle has no effect
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (ld_rdy_v[s] !== 1'b1 || valid_v[s] !== 1'b0 || ws_v[s] !== 16'd0) begin
        bad++; $display("FAIL idle_ready_no_effect s=%0d got lr/v=%b%b ws=%0d exp=10 ws=0",
                        s, ld_rdy_v[s], valid_v[s], ws_v[s]);
      end
    end
  endtask

  task automatic test_msb_first();
    send_word(0, 32'hA5, 0, 1'b0);
  endtask

  task automatic test_lsb_first();
    send_word(1, 32'hA5, 0, 1'b0);
    send_word(1, 32'h01, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_word(2, 32'hDEADBEEF, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1;
    logic [7:0] w2;
    logic       eb;
    w1 = 8'h3C; w2 = 8'hC3;
    @(negedge clk);
    rdy = 1'b1; d = {24'd0, w1}; lv[0] = 1'b1;
    @(posedge clk); #1;
    d = {24'd0, w2};
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      if (t == 10) lv[0] = 1'b0;
      if (t == 9 || t == 18) begin
        total++;
        if (ld_rdy_v[0] !== 1'b1 || valid_v[0] !== 1'b0) begin
          bad++; $display("FAIL b2b_gap t=%0d got lr/v=%b%b exp=10", t, ld_rdy_v[0], valid_v[0]);
        end
        total++;
        if (ws_v[0] !== 16'((exp_ws[0] + (t == 9 ? 1 : 2)) % 65536)) begin
          bad++; $display("FAIL b2b_words_sent t=%0d got=%0d exp=%0d", t, ws_v[0],
                          (exp_ws[0] + (t == 9 ? 1 : 2)) % 65536);
        end
      end else begin
        eb = (t < 9) ? w1[8-t] : w2[17-t];
        total++;
        if (valid_v[0] !== 1'b1 || sdo_v[0] !== eb) begin
          bad++; $display("FAIL b2b_bit t=%0d got v/sdo=%b%b exp=1%b", t, valid_v[0], sdo_v[0], eb);
        end
        total++;
        if (last_v[0] !== (t == 8 || t == 17)) begin
          bad++; $display("FAIL b2b_last t=%0d got=%b exp=%b", t, last_v[0], (t == 8 || t == 17));
        end
      end
    end
    exp_ws[0] = (exp_ws[0] + 2) % 65536;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rdy = 1'b1; d = 32'hFF; lv[0] = 1'b1;
    @(posedge clk); #1;
    lv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({ld_rdy_v[s], valid_v[s], busy_v[s], last_v[s], sdo_v[s]} !== 5'b10000 || ws_v[s] !== 16'd0) begin
        bad++; $display("FAIL async_reset s=%0d got lr/v/b/l/sdo=%b%b%b%b%b ws=%0d exp=10000 ws=0",
                        s, ld_rdy_v[s], valid_v[s], busy_v[s], last_v[s], sdo_v[s], ws_v[s]);
      end
      exp_ws[s] = 0;
    end
    exp_q.delete();
    // load_valid during reset is not captured
    d = 32'h55; lv[0] = 1'b1;
    @(posedge clk); #1;
    lv[0] = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy_v[0] !== 1'b0 || ld_rdy_v[0] !== 1'b1) begin
      bad++; $display("FAIL reset_beats_load got b/lr=%b%b exp=01", busy_v[0], ld_rdy_v[0]);
    end
    send_word(0, 32'h81, 0, 1'b0);
  endtask

  task automatic test_random();
    int          s;
    logic [31:0] w;
    for (int i = 0; i < 20; i++) begin
      s = $urandom_range(0, 2);
      w = $urandom;
      send_word(s, w, 1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
